// File: rtl/gmii_clk_en_gen_pkg.sv
// ---------------------------------------------------------------------------
// gmii_clk_pkg
//
// Shared types and helpers for the gmii_to_10G clock-enable generator.
//   speed_t     : 2-bit speed code (10M / 100M / 1000M / reserved)
//   speed2div   : maps an active speed code onto its enable period
//   max3        : largest of three divisors
//   cntWidth    : counter width able to hold (largest divisor - 1)
// ---------------------------------------------------------------------------
package gmii_clk_pkg;

  typedef enum logic [1:0] {
    SPEED_10M   = 2'b00,
    SPEED_100M  = 2'b01,
    SPEED_1000M = 2'b10,
    SPEED_RSVD  = 2'b11
  } speed_t;

  // The reserved code can never become the active speed, so its result is
  // irrelevant; the slowest period is returned as a safe fallback.
  function automatic int unsigned speed2div(input speed_t      speed,
                                            input int unsigned d10,
                                            input int unsigned d100,
                                            input int unsigned d1000);
    int unsigned div;
    case (speed)
      SPEED_10M:   div = d10;
      SPEED_100M:  div = d100;
      SPEED_1000M: div = d1000;
      default:     div = d10;
    endcase
    return div;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // At least one bit, even when every divisor is 1.
  function automatic int unsigned cntWidth(input int unsigned d10,
                                           input int unsigned d100,
                                           input int unsigned d1000);
    int unsigned w;
    w = $clog2(max3(d10, d100, d1000));
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/gmii_clk_en_gen_if.sv
// ---------------------------------------------------------------------------
// gmii_clk_en_gen_if
//
// Bundles the per-channel request and status signals of the clock-enable
// generator. The MAC side uses the master modport, the generator the slave.
//   speed_sel_i  : requested speed per channel (2 bits each)
//   ch_en_i      : per-channel run enable
//   sync_i       : one-cycle pulse re-phasing every channel
//   clk_en_o     : per-channel data-qualifying enable pulse
//   speed_o      : active speed per channel
//   speed_chg_o  : one-cycle pulse when a channel's active speed changes
// ---------------------------------------------------------------------------
interface gmii_clk_en_gen_if #(
  parameter int NUM_CH = 2
);

  logic [NUM_CH-1:0][1:0] speed_sel_i;
  logic [NUM_CH-1:0]      ch_en_i;
  logic                   sync_i;
  logic [NUM_CH-1:0]      clk_en_o;
  logic [NUM_CH-1:0][1:0] speed_o;
  logic [NUM_CH-1:0]      speed_chg_o;

  modport master (
    output speed_sel_i,
    output ch_en_i,
    output sync_i,
    input  clk_en_o,
    input  speed_o,
    input  speed_chg_o
  );

  modport slave (
    input  speed_sel_i,
    input  ch_en_i,
    input  sync_i,
    output clk_en_o,
    output speed_o,
    output speed_chg_o
  );

endinterface

// File: rtl/gmii_clk_en_gen_ch.sv
// ---------------------------------------------------------------------------
// gmii_clk_en_ch
//
// One channel of the clock-enable generator: period counter, active speed
// register and registered outputs.
//   clk_i        : system clock
//   rst_i        : synchronous active-high reset
//   speed_sel_i  : requested speed code
//   ch_en_i      : channel run enable
//   sync_i       : restart the period
//   clk_en_o     : enable pulse, high on the edge that ends a period
//   speed_o      : active speed code
//   speed_chg_o  : one-cycle pulse when speed_o changes
// ---------------------------------------------------------------------------
module gmii_clk_en_ch
  import gmii_clk_pkg::*;
#(
  parameter int unsigned DIV_1000M = 1,
  parameter int unsigned DIV_100M  = 10,
  parameter int unsigned DIV_10M   = 100,
  parameter logic [1:0]  RST_SPEED = 2'b10,
  parameter int unsigned CNT_W     = cntWidth(DIV_10M, DIV_100M, DIV_1000M)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] speed_sel_i,
  input  logic       ch_en_i,
  input  logic       sync_i,
  output logic       clk_en_o,
  output logic [1:0] speed_o,
  output logic       speed_chg_o
);

  logic [CNT_W-1:0] r_cnt;
  speed_t           r_speed;
  logic             r_clkEn;
  logic             r_speedChg;

  logic [CNT_W-1:0] w_termCnt;
  speed_t           w_reqSpeed;
  logic             w_applySpeed;

  // The divisor follows the active speed, never the raw request, so a request
  // arriving mid-period cannot shorten or stretch the running period. The
  // subtraction is done at 32 bits before narrowing, as a power-of-two divisor
  // itself would not fit in CNT_W.
  always_comb begin
    w_termCnt    = CNT_W'(speed2div(r_speed, DIV_10M, DIV_100M, DIV_1000M) - 32'd1);
    w_reqSpeed   = speed_t'(speed_sel_i);
    w_applySpeed = (w_reqSpeed != r_speed) && (w_reqSpeed != SPEED_RSVD);
  end

  // Priority: reset, channel disable, sync, terminal count, count. The speed
  // register is only ever updated on a period boundary (sync or terminal), so
  // the new divisor governs exactly the period starting on that edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_clkEn    <= 1'b0;
      r_speed    <= speed_t'(RST_SPEED);
      r_speedChg <= 1'b0;
    end else if (!ch_en_i) begin
      r_cnt      <= '0;
      r_clkEn    <= 1'b0;
      r_speedChg <= 1'b0;
    end else if (sync_i || (r_cnt == w_termCnt)) begin
      r_cnt      <= '0;
      // A sync coincident with the terminal count suppresses the pulse.
      r_clkEn    <= !sync_i;
      r_speedChg <= w_applySpeed;
      if (w_applySpeed) begin
        r_speed <= w_reqSpeed;
      end
    end else begin
      r_cnt      <= r_cnt + 1'b1;
      r_clkEn    <= 1'b0;
      r_speedChg <= 1'b0;
    end
  end

  assign clk_en_o    = r_clkEn;
  assign speed_o     = r_speed;
  assign speed_chg_o = r_speedChg;

endmodule

// File: rtl/gmii_clk_en_gen.sv
// ---------------------------------------------------------------------------
// gmii_clk_en_gen
//
// Multi-channel clock-enable generator for the gmii_to_10G path. Each channel
// produces its own enable pulse stream at 10/100/1000M rates from the single
// system clock; sync_i re-phases every channel together.
//   clk_i  : system clock, all logic on its rising edge
//   rst_i  : synchronous active-high reset
//   bus    : slave side of gmii_clk_en_gen_if (requests in, enables/status out)
// ---------------------------------------------------------------------------
module gmii_clk_en_gen
  import gmii_clk_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int unsigned DIV_1000M = 1,
  parameter int unsigned DIV_100M  = 10,
  parameter int unsigned DIV_10M   = 100,
  parameter logic [1:0]  RST_SPEED = 2'b10
) (
  input logic               clk_i,
  input logic               rst_i,
  gmii_clk_en_gen_if.slave  bus
);

  localparam int unsigned CNT_W = cntWidth(DIV_10M, DIV_100M, DIV_1000M);

  // Channels share nothing but clock, reset and the sync pulse.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    gmii_clk_en_ch #(
      .DIV_1000M (DIV_1000M),
      .DIV_100M  (DIV_100M),
      .DIV_10M   (DIV_10M),
      .RST_SPEED (RST_SPEED),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .speed_sel_i (bus.speed_sel_i[g]),
      .ch_en_i     (bus.ch_en_i[g]),
      .sync_i      (bus.sync_i),
      .clk_en_o    (bus.clk_en_o[g]),
      .speed_o     (bus.speed_o[g]),
      .speed_chg_o (bus.speed_chg_o[g])
    );
  end

endmodule

// File: tb/tb_gmii_clk_en_gen.sv
// ---------------------------------------------------------------------------
// tb_gmii_clk_en_gen
//
// Directed bench for gmii_clk_en_gen with two channels and divisors 1/10/100.
// ---------------------------------------------------------------------------
module tb_gmii_clk_en_gen;

  logic clk;
  logic rst;
  int   cmpCount;
  int   errCount;

  gmii_clk_en_gen_if #(.NUM_CH(2)) bus ();

  gmii_clk_en_gen #(
    .NUM_CH    (2),
    .DIV_1000M (1),
    .DIV_100M  (10),
    .DIV_10M   (100),
    .RST_SPEED (2'b10)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with the given requests; reset stays asserted.
  task automatic applyReset(input logic [1:0] sel0, input logic [1:0] sel1,
                            input logic [1:0] en);
    rst               = 1'b1;
    bus.speed_sel_i[0] = sel0;
    bus.speed_sel_i[1] = sel1;
    bus.ch_en_i       = en;
    bus.sync_i        = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    applyReset(2'b10, 2'b10, 2'b11);
    cmpCount++;
    if (bus.clk_en_o !== 2'b00) begin
      $display("[TB] FAIL reset_clk_en: got %b want 00", bus.clk_en_o);
      errCount++;
    end
    cmpCount++;
    if (bus.speed_o !== 4'b1010) begin
      $display("[TB] FAIL reset_speed: got %b want 1010", bus.speed_o);
      errCount++;
    end
    cmpCount++;
    if (bus.speed_chg_o !== 2'b00) begin
      $display("[TB] FAIL reset_speed_chg: got %b want 00", bus.speed_chg_o);
      errCount++;
    end
  endtask

  // Channel 0 at 1000M: enable is high on every edge from edge 1.
  task automatic test_1000m();
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      cmpCount++;
      if (bus.clk_en_o[0] !== 1'b1) begin
        $display("[TB] FAIL 1000m_clk_en edge %0d: got %b want 1", e, bus.clk_en_o[0]);
        errCount++;
      end
      cmpCount++;
      if (bus.speed_chg_o !== 2'b00) begin
        $display("[TB] FAIL 1000m_speed_chg edge %0d: got %b want 00", e, bus.speed_chg_o);
        errCount++;
      end
    end
  endtask

  // Channel 1 requests 100M at reset release.
  task automatic test_speed_change_100m();
    applyReset(2'b10, 2'b01, 2'b11);
    rst = 1'b0;
    tick();
    cmpCount++;
    if (bus.speed_chg_o[1] !== 1'b1 || bus.speed_o[1] !== 2'b01) begin
      $display("[TB] FAIL chg100_edge1: got chg=%b speed=%b want chg=1 speed=01",
               bus.speed_chg_o[1], bus.speed_o[1]);
      errCount++;
    end
    for (int e = 2; e <= 21; e++) begin
      tick();
      cmpCount++;
      if (bus.clk_en_o[1] !== ((e == 11) || (e == 21))) begin
        $display("[TB] FAIL chg100_clk_en edge %0d: got %b want %b", e,
                 bus.clk_en_o[1], (e == 11) || (e == 21));
        errCount++;
      end
      cmpCount++;
      if (bus.speed_chg_o[1] !== 1'b0 || bus.speed_o[1] !== 2'b01) begin
        $display("[TB] FAIL chg100_hold edge %0d: got chg=%b speed=%b want chg=0 speed=01",
                 e, bus.speed_chg_o[1], bus.speed_o[1]);
        errCount++;
      end
    end
  endtask

  // Channel 0 at 10M, 100M requested at cnt=37, applied only at the terminal.
  task automatic test_10m_midperiod();
    applyReset(2'b00, 2'b10, 2'b11);
    rst = 1'b0;
    tick();
    cmpCount++;
    if (bus.speed_o[0] !== 2'b00 || bus.speed_chg_o[0] !== 1'b1) begin
      $display("[TB] FAIL 10m_enter: got speed=%b chg=%b want speed=00 chg=1",
               bus.speed_o[0], bus.speed_chg_o[0]);
      errCount++;
    end
    for (int t = 1; t <= 99; t++) begin
      tick();
      if (t == 37) bus.speed_sel_i[0] = 2'b01;
      cmpCount++;
      if (bus.clk_en_o[0] !== 1'b0 || bus.speed_o[0] !== 2'b00 || bus.speed_chg_o[0] !== 1'b0) begin
        $display("[TB] FAIL 10m_hold t=%0d: got en=%b speed=%b chg=%b want en=0 speed=00 chg=0",
                 t, bus.clk_en_o[0], bus.speed_o[0], bus.speed_chg_o[0]);
        errCount++;
      end
    end
    tick();
    cmpCount++;
    if (bus.clk_en_o[0] !== 1'b1 || bus.speed_o[0] !== 2'b01 || bus.speed_chg_o[0] !== 1'b1) begin
      $display("[TB] FAIL 10m_switch: got en=%b speed=%b chg=%b want en=1 speed=01 chg=1",
               bus.clk_en_o[0], bus.speed_o[0], bus.speed_chg_o[0]);
      errCount++;
    end
    for (int t = 1; t <= 10; t++) begin
      tick();
      cmpCount++;
      if (bus.clk_en_o[0] !== (t == 10) || bus.speed_chg_o[0] !== 1'b0) begin
        $display("[TB] FAIL 10m_next_period t=%0d: got en=%b chg=%b want en=%b chg=0",
                 t, bus.clk_en_o[0], bus.speed_chg_o[0], t == 10);
        errCount++;
      end
    end
  endtask

  // Reserved code on channel 0 (at 100M, just after a pulse) is ignored.
  task automatic test_reserved();
    bus.speed_sel_i[0] = 2'b11;
    for (int i = 1; i <= 300; i++) begin
      tick();
      cmpCount++;
      if (bus.clk_en_o[0] !== ((i % 10) == 0) || bus.speed_o[0] !== 2'b01 ||
          bus.speed_chg_o[0] !== 1'b0) begin
        $display("[TB] FAIL rsvd i=%0d: got en=%b speed=%b chg=%b want en=%b speed=01 chg=0",
                 i, bus.clk_en_o[0], bus.speed_o[0], bus.speed_chg_o[0], (i % 10) == 0);
        errCount++;
      end
    end
  endtask

  // Offset channels re-phased by sync, then sync coincident with terminal.
  task automatic test_sync();
    applyReset(2'b01, 2'b01, 2'b11);
    rst = 1'b0;
    tick();
    bus.ch_en_i[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cmpCount++;
      if (bus.clk_en_o[1] !== 1'b0 || bus.speed_o[1] !== 2'b01) begin
        $display("[TB] FAIL sync_offset_dis: got en=%b speed=%b want en=0 speed=01",
                 bus.clk_en_o[1], bus.speed_o[1]);
        errCount++;
      end
    end
    bus.ch_en_i[1] = 1'b1;
    tick();
    tick();
    tick();
    bus.sync_i = 1'b1;
    tick();
    bus.sync_i = 1'b0;
    cmpCount++;
    if (bus.clk_en_o !== 2'b00) begin
      $display("[TB] FAIL sync_edge: got %b want 00", bus.clk_en_o);
      errCount++;
    end
    for (int t = 1; t <= 30; t++) begin
      if (t == 20) bus.sync_i = 1'b1;
      tick();
      bus.sync_i = 1'b0;
      cmpCount++;
      if (bus.clk_en_o !== (((t == 10) || (t == 30)) ? 2'b11 : 2'b00)) begin
        $display("[TB] FAIL sync_realign t=%0d: got %b want %b", t, bus.clk_en_o,
                 ((t == 10) || (t == 30)) ? 2'b11 : 2'b00);
        errCount++;
      end
    end
  endtask

  // Channel 1 disabled at cnt=5 for 20 cycles, then re-enabled.
  task automatic test_ch_disable();
    for (int i = 0; i < 5; i++) tick();
    bus.ch_en_i[1] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      cmpCount++;
      if (bus.clk_en_o[1] !== 1'b0 || bus.speed_o[1] !== 2'b01 || bus.speed_chg_o[1] !== 1'b0) begin
        $display("[TB] FAIL dis_hold i=%0d: got en=%b speed=%b chg=%b want en=0 speed=01 chg=0",
                 i, bus.clk_en_o[1], bus.speed_o[1], bus.speed_chg_o[1]);
        errCount++;
      end
    end
    bus.ch_en_i[1] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      cmpCount++;
      if (bus.clk_en_o[1] !== (t == 10)) begin
        $display("[TB] FAIL dis_restart t=%0d: got %b want %b", t, bus.clk_en_o[1], t == 10);
        errCount++;
      end
    end
  endtask

  // Reset mid-period returns every output to its reset value.
  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    cmpCount++;
    if (bus.clk_en_o !== 2'b00 || bus.speed_o !== 4'b1010 || bus.speed_chg_o !== 2'b00) begin
      $display("[TB] FAIL reset_mid: got en=%b speed=%b chg=%b want en=00 speed=1010 chg=00",
               bus.clk_en_o, bus.speed_o, bus.speed_chg_o);
      errCount++;
    end
    rst = 1'b0;
  endtask

  initial begin
    cmpCount = 0;
    errCount = 0;
    rst      = 1'b1;
    bus.speed_sel_i = '0;
    bus.ch_en_i     = '0;
    bus.sync_i      = 1'b0;
    test_reset();
    test_1000m();
    test_speed_change_100m();
    test_10m_midperiod();
    test_reserved();
    test_sync();
    test_ch_disable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
